// File: rtl/cpu5_memarb_pkg.sv
// Shared constants and state encoding for the cpu5 unified-memory arbiter.
// Imported by the arbiter top and its watchdog sub-module.
package cpu5_memarb_pkg;

  localparam int CPU5_XLEN              = 32;
  localparam int CPU5_MEMARB_TIMEOUT    = 16;
  localparam int CPU5_MEMARB_LS_STREAK  = 4;
  localparam int CPU5_MEMARB_STATE_SIZE = 2;

  typedef enum logic [CPU5_MEMARB_STATE_SIZE-1:0] {
    CPU5_MEMARB_IDLE    = 2'd0,
    CPU5_MEMARB_WAIT_IF = 2'd1,
    CPU5_MEMARB_WAIT_LS = 2'd2,
    CPU5_MEMARB_DRAIN   = 2'd3
  } memarb_state_e;

  // Bits needed to hold a counter value in the range 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpu5_memarb_wdog.sv
// Response watchdog: counts cycles spent waiting on memory and flags the
// last allowed wait cycle so the arbiter can report a timeout.
module cpu5_memarb_wdog
  import cpu5_memarb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CPU5_MEMARB_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/cpu5_memarb.sv
// Arbitrates one unified memory port between instruction fetch and load/store.
// One outstanding transaction; LS has priority, bounded by a streak limit.
module cpu5_memarb
  import cpu5_memarb_pkg::*;
#(
  parameter int XLEN           = CPU5_XLEN,
  parameter int TIMEOUT_CYCLES = CPU5_MEMARB_TIMEOUT,
  parameter int LS_MAX_STREAK  = CPU5_MEMARB_LS_STREAK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [XLEN/8-1:0] ls_wstrb,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  localparam int SW = cnt_width(LS_MAX_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LS_MAX_STREAK);

  memarb_state_e state;
  logic [SW-1:0] streak;
  logic          idle;
  logic          in_wait;
  logic          expired;
  logic          ls_win;
  logic          if_win;
  logic          xfer;
  logic          resp_ok;
  logic          resp_to;

  // Every output is gated by reset so they all read 0 while it is held.
  assign idle    = reset && (state == CPU5_MEMARB_IDLE);
  assign in_wait = reset && ((state == CPU5_MEMARB_WAIT_IF) || (state == CPU5_MEMARB_WAIT_LS));

  // LS wins unless IF has been passed over LS_MAX_STREAK times in a row.
  assign ls_win = idle && ls_req && !(if_req && (streak == STREAK_MAX));
  assign if_win = idle && if_req && !ls_win;
  assign xfer   = (ls_win || if_win) && mem_ready;

  assign ls_gnt = ls_win && mem_ready;
  assign if_gnt = if_win && mem_ready;
  assign busy   = reset && (state != CPU5_MEMARB_IDLE);

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (ls_win) begin
      mem_req   = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_wstrb = ls_wstrb;
    end else if (if_win) begin
      mem_req   = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // A real response always beats a timeout landing in the same cycle.
  assign resp_ok = in_wait && mem_rvalid;
  assign resp_to = in_wait && !mem_rvalid && expired;

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    ls_err    = 1'b0;
    if (state == CPU5_MEMARB_WAIT_IF) begin
      if_rvalid = resp_ok || resp_to;
      if_err    = resp_to;
      if_rdata  = resp_ok ? mem_rdata : '0;
    end else if (state == CPU5_MEMARB_WAIT_LS) begin
      ls_rvalid = resp_ok || resp_to;
      ls_err    = resp_to;
      ls_rdata  = resp_ok ? mem_rdata : '0;
    end
  end

  cpu5_memarb_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_wait || mem_rvalid),
    .en      (in_wait),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= CPU5_MEMARB_IDLE;
      streak <= '0;
    end else begin
      case (state)
        CPU5_MEMARB_IDLE: begin
          if (xfer) begin
            state <= ls_win ? CPU5_MEMARB_WAIT_LS : CPU5_MEMARB_WAIT_IF;
            if (ls_win && if_req) begin
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            end else begin
              streak <= '0;
            end
          end
        end
        CPU5_MEMARB_WAIT_IF, CPU5_MEMARB_WAIT_LS: begin
          if (mem_rvalid) begin
            state <= CPU5_MEMARB_IDLE;
          end else if (expired) begin
            state <= CPU5_MEMARB_DRAIN;
          end
        end
        CPU5_MEMARB_DRAIN: begin
          // The late response to the timed-out request is swallowed here.
          if (mem_rvalid) begin
            state <= CPU5_MEMARB_IDLE;
          end
        end
        default: state <= CPU5_MEMARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu5_memarb.sv
// Self-checking bench for cpu5_memarb: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_cpu5_memarb;

  localparam int XLEN = 32;
  localparam int SB   = XLEN / 8;
  localparam int TO   = 16;
  localparam int MS   = 4;
  localparam int OW   = 9 + 4 * XLEN + SB;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt, if_rvalid, if_err;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req, ls_we;
  logic [XLEN-1:0] ls_addr, ls_wdata;
  logic [SB-1:0]   ls_wstrb;
  logic            ls_gnt, ls_rvalid, ls_err;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [SB-1:0]   mem_wstrb;
  logic            mem_ready, mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  logic [OW-1:0] all_out;
  assign all_out = {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                    mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy};

  cpu5_memarb #(
    .XLEN(XLEN), .TIMEOUT_CYCLES(TO), .LS_MAX_STREAK(MS)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80;
    ls_wdata = 32'hFFFF; ls_wstrb = 4'hF; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_if();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    #1;
    total++;
    if ({if_gnt, ls_gnt, mem_req, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0}) begin
      bad++; $display("FAIL single_if_grant gnt=%b mem_req=%b addr=%h busy=%b exp gnt=1 req=1 addr=100 busy=0",
                      if_gnt, mem_req, mem_addr, busy);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if_req = 1'b0;
      mem_rvalid = (c == 3);
      mem_rdata = (c == 3) ? 32'hDEADBEEF : $urandom;
      #1;
      total++;
      if ({busy, mem_req, if_rvalid, if_err, if_rdata, ls_rvalid} !==
          {1'b1, 1'b0, (c == 3), 1'b0, ((c == 3) ? 32'hDEADBEEF : 32'h0), 1'b0}) begin
        bad++; $display("FAIL single_if_wait c=%0d busy=%b rvalid=%b err=%b rdata=%h exp rvalid=%0d",
                        c, busy, if_rvalid, if_err, if_rdata, (c == 3));
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_if_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h140;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h55AA; ls_wstrb = 4'hF;
    #1;
    total++;
    if ({ls_gnt, if_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55AA, 4'hF}) begin
      bad++; $display("FAIL simul_ls_first ls_gnt=%b if_gnt=%b we=%b addr=%h wdata=%h wstrb=%h",
                      ls_gnt, if_gnt, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = '0;
    #1;
    total++;
    if ({ls_rvalid, ls_err, if_gnt, mem_req, if_rvalid} !== 5'b10000) begin
      bad++; $display("FAIL simul_ls_resp got=%b exp=10000", {ls_rvalid, ls_err, if_gnt, mem_req, if_rvalid});
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    total++;
    if ({if_gnt, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h140, 1'b0, 32'h0, 4'h0}) begin
      bad++; $display("FAIL simul_if_next if_gnt=%b addr=%h we=%b wdata=%h wstrb=%h exp 1/140/0/0/0",
                      if_gnt, mem_addr, mem_we, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    total++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hCAFE}) begin
      bad++; $display("FAIL simul_if_resp rvalid=%b rdata=%h exp 1/cafe", if_rvalid, if_rdata);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_fairness();
    bit   granted_prev;
    logic [XLEN-1:0] e;
    granted_prev = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back((i % 5 == 4) ? 32'd0 : 32'd1);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h500;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
      mem_rvalid = granted_prev; mem_rdata = $urandom;
      #1;
      granted_prev = 1'b0;
      if (if_gnt || ls_gnt) begin
        e = exp_q.pop_front();
        total++;
        if ({if_gnt, ls_gnt} !== {~e[0], e[0]}) begin
          bad++; $display("FAIL fairness_order grant=%0d if_gnt=%b ls_gnt=%b exp_ls=%0d",
                          11 - exp_q.size(), if_gnt, ls_gnt, e[0]);
        end
        granted_prev = 1'b1;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL fairness_budget missing=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0; mem_rvalid = granted_prev;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
    #1;
    total++;
    if (ls_gnt !== 1'b1) begin
      bad++; $display("FAIL timeout_grant ls_gnt=%b exp=1", ls_gnt);
    end
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      ls_req = 1'b0; mem_rdata = $urandom;
      #1;
      total++;
      if ({ls_rvalid, ls_err, ls_rdata} !== {(c == TO), (c == TO), 32'h0}) begin
        bad++; $display("FAIL timeout_wait c=%0d rvalid=%b err=%b rdata=%h exp rvalid=err=%0d rdata=0",
                        c, ls_rvalid, ls_err, ls_rdata, (c == TO));
      end
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h600;
      mem_rvalid = (c == 3); mem_rdata = 32'h1234;
      #1;
      total++;
      if ({if_gnt, mem_req, if_rvalid, ls_rvalid, busy} !== 5'b00001) begin
        bad++; $display("FAIL timeout_drain c=%0d got=%b exp=00001", c, {if_gnt, mem_req, if_rvalid, ls_rvalid, busy});
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    total++;
    if ({if_gnt, mem_addr, busy} !== {1'b1, 32'h600, 1'b0}) begin
      bad++; $display("FAIL timeout_next_if if_gnt=%b addr=%h busy=%b exp 1/600/0", if_gnt, mem_addr, busy);
    end
    @(negedge clk);
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    total++;
    if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'h77}) begin
      bad++; $display("FAIL timeout_if_resp rvalid=%b err=%b rdata=%h exp 1/0/77", if_rvalid, if_err, if_rdata);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h700; mem_ready = 1'b0;
      #1;
      total++;
      if ({mem_req, mem_addr, if_gnt, ls_gnt} !== {1'b1, 32'h700, 1'b0, 1'b0}) begin
        bad++; $display("FAIL stall_hold c=%0d req=%b addr=%h if_gnt=%b exp 1/700/0", c, mem_req, mem_addr, if_gnt);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h700}) begin
      bad++; $display("FAIL stall_release if_gnt=%b addr=%h exp 1/700", if_gnt, mem_addr);
    end
    @(negedge clk);
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h9;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h800;
    @(negedge clk);
    if_req = 1'b0;
    #2;
    reset = 1'b0;
    if_req = 1'b1; ls_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hABCD;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_mid_async got=%h exp=0", all_out);
    end
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b1;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_mid_stale got=%h exp=0", all_out);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  // Randomized traffic against a transaction-level model of the arbiter.
  task automatic test_random();
    int owner, waited, streak_m, rem, d;
    bit draining, if_gnt_d, ls_gnt_d, lw, iw;
    logic e_if_gnt, e_if_rv, e_if_err, e_ls_gnt, e_ls_rv, e_ls_err, e_req, e_we, e_busy;
    logic [XLEN-1:0] e_if_rd, e_ls_rd, e_addr, e_wdata;
    logic [SB-1:0] e_wstrb;
    logic [OW-1:0] exp_v;
    owner = 0; waited = 0; streak_m = 0; rem = -1; draining = 0; if_gnt_d = 0; ls_gnt_d = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (if_req && if_gnt_d) if_req = 1'b0;
      if (ls_req && ls_gnt_d) ls_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!ls_req && $urandom_range(0, 1) == 0) begin
        ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom;
        ls_wdata = $urandom; ls_wstrb = SB'($urandom_range(0, 15));
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      mem_rvalid = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin mem_rvalid = 1'b1; rem = -1; end
      end else if (owner == 0 && !draining && $urandom_range(0, 9) == 0) begin
        mem_rvalid = 1'b1;
      end
      #1;
      e_if_gnt = 0; e_if_rv = 0; e_if_err = 0; e_ls_gnt = 0; e_ls_rv = 0; e_ls_err = 0;
      e_req = 0; e_we = 0; e_if_rd = '0; e_ls_rd = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      e_busy = (owner != 0) || draining;
      if (owner == 0 && !draining) begin
        lw = ls_req && !(if_req && streak_m == MS);
        iw = !lw && if_req;
        e_req = lw || iw;
        if (lw) begin e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata; e_wstrb = ls_wstrb; end
        else if (iw) e_addr = if_addr;
        e_ls_gnt = lw && mem_ready;
        e_if_gnt = iw && mem_ready;
      end else if (owner != 0) begin
        if (mem_rvalid || waited == TO - 1) begin
          if (owner == 1) begin
            e_if_rv = 1; e_if_err = !mem_rvalid; e_if_rd = mem_rvalid ? mem_rdata : '0;
          end else begin
            e_ls_rv = 1; e_ls_err = !mem_rvalid; e_ls_rd = mem_rvalid ? mem_rdata : '0;
          end
        end
      end
      exp_v = {e_if_gnt, e_if_rv, e_if_rd, e_if_err, e_ls_gnt, e_ls_rv, e_ls_rd, e_ls_err,
               e_req, e_we, e_addr, e_wdata, e_wstrb, e_busy};
      total++;
      if (all_out !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, all_out, exp_v);
      end
      if_gnt_d = e_if_gnt; ls_gnt_d = e_ls_gnt;
      if (owner == 0 && !draining) begin
        if (e_if_gnt || e_ls_gnt) begin
          owner = e_ls_gnt ? 2 : 1;
          waited = 0;
          streak_m = (e_ls_gnt && if_req) ? ((streak_m < MS) ? streak_m + 1 : MS) : 0;
          d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(1, 4);
          rem = d;
        end
      end else if (owner != 0) begin
        if (mem_rvalid) owner = 0;
        else if (waited == TO - 1) begin owner = 0; draining = 1; end
        else waited++;
      end else if (mem_rvalid) begin
        draining = 0;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_single_if();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
